// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared FSM state type, mode encodings and gap counter width for the LED sequencer.
package led_seq_pkg;
    typedef enum logic [1:0] {IDLE, START, BREATHE, GAP} state_t;
    localparam logic MODE_FWD      = 1'b0;
    localparam logic MODE_PINGPONG = 1'b1;
    localparam int   GAP_W         = 8;
endpackage

// File: rtl/led_sequencer_gap_timer.sv
// gap_timer: loadable down-counter that parks at zero; expired is high while the count is zero.
module gap_timer
    import led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [GAP_W-1:0] load_value,
    output logic [GAP_W-1:0] value,
    output logic             expired
);
    assign expired = value == '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            value <= '0;
        else if (load)
            value <= load_value;
        else if (!expired)
            value <= value - GAP_W'(1);
    end
endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: walks one breath per LED (forward chase or ping-pong) with idle gaps between breaths.
// Define LED_SEQ_ACTIVE_LOW_EN for an active-low led bus (inactive = 1, reset value all ones).
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter  int N_LEDS     = 8,
    parameter  int GAP_CYCLES = 16,
    localparam int IW         = N_LEDS > 1 ? $clog2(N_LEDS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              stop,
    input  logic              mode,
    input  logic              loop_en,
    input  logic              pwm_in,
    input  logic              done_in,
    output logic              start_out,
    output logic [N_LEDS-1:0] led,
    output logic [IW-1:0]     led_idx,
    output logic              busy,
    output logic              seq_done
);
    localparam logic [IW-1:0]    IDX_MAX  = IW'(N_LEDS - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
`ifdef LED_SEQ_ACTIVE_LOW_EN
    localparam logic [N_LEDS-1:0] LED_OFF = '1;
`else
    localparam logic [N_LEDS-1:0] LED_OFF = '0;
`endif

    state_t           state, state_next;
    logic             dir_down, mode_q, last, move_up, done_ev, dir_next;
    logic             gap_load, gap_expired, unused_gap;
    logic [IW-1:0]    idx_next;
    logic [GAP_W-1:0] gap_value;

    gap_timer u_gap (
        .clk        (clk),
        .rst        (rst),
        .load       (gap_load),
        .load_value (GAP_LOAD),
        .value      (gap_value),
        .expired    (gap_expired)
    );

    assign unused_gap = ^gap_value;
    assign done_ev    = state == BREATHE && done_in && !stop;
    assign last       = N_LEDS == 1 || (mode_q == MODE_FWD ? led_idx == IDX_MAX : dir_down && led_idx == '0);
    // Ping-pong bounces off both ends so the end LEDs are never lit twice in a row.
    assign move_up    = mode_q == MODE_FWD || led_idx == '0 || (!dir_down && led_idx != IDX_MAX);
    assign idx_next   = (N_LEDS == 1 || (mode_q == MODE_FWD && last)) ? '0
                      : move_up ? led_idx + IW'(1) : led_idx - IW'(1);
    assign dir_next   = mode_q == MODE_PINGPONG && (!move_up || idx_next == IDX_MAX);
    assign gap_load   = state == BREATHE && state_next == GAP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_idx  <= '0;
            dir_down <= 1'b0;
            mode_q   <= MODE_FWD;
            seq_done <= 1'b0;
        end else begin
            seq_done <= done_ev && last;
            if (state == IDLE && go && !stop) begin
                led_idx  <= '0;
                dir_down <= 1'b0;
                mode_q   <= mode;
            end else if (done_ev && (!last || loop_en)) begin
                led_idx  <= idx_next;
                dir_down <= dir_next;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = go ? START : IDLE;
            START:   state_next = BREATHE;
            BREATHE: if (done_in) state_next = (last && !loop_en) ? IDLE : (GAP_CYCLES == 0 ? START : GAP);
            GAP:     state_next = gap_expired ? START : GAP;
        endcase
        if (stop)
            state_next = IDLE;
    end

    always_comb begin
        start_out = state == START;
        busy      = state != IDLE;
        led       = LED_OFF ^ ((state == BREATHE && !stop) ? N_LEDS'(pwm_in) << led_idx : '0);
    end
endmodule
